// File: rtl/sccomp_dbg_ctrl_if.sv
// ---------------------------------------------------------------------------
// sccomp_dbg_ctrl_if
// Host-side bundle of the sccomp debug controller. It carries three streams:
//   cmd_*  : host -> controller command channel (valid/ready, op, argument)
//   ld_*   : host -> controller instruction-word stream used by LOAD
//   dump_* : controller -> host register-dump stream (valid/ready, idx, data)
// The master modport is the host side and the slave modport is the controller.
// ---------------------------------------------------------------------------
interface sccomp_dbg_ctrl_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [31:0] cmd_arg;

   logic        ld_valid;
   logic        ld_ready;
   logic [31:0] ld_data;

   logic        dump_valid;
   logic        dump_ready;
   logic [31:0] dump_data;
   logic [4:0]  dump_idx;

   modport master (
      output cmd_valid, cmd_op, cmd_arg, ld_valid, ld_data, dump_ready,
      input  cmd_ready, ld_ready, dump_valid, dump_data, dump_idx
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_arg, ld_valid, ld_data, dump_ready,
      output cmd_ready, ld_ready, dump_valid, dump_data, dump_idx
   );
endinterface

// File: rtl/sccomp_dbg_ctrl.sv
// ---------------------------------------------------------------------------
// sccomp_dbg_ctrl
// Run-control and debug sequencer for the single-cycle CPU. It loads the
// instruction memory from a host word stream, drives the CPU reset and clock
// enable, implements RUN / STEP / HALT with one PC breakpoint, and streams
// out all 32 CPU registers by sweeping the register-read port.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   host (slave)      command, load-word and dump streams
//   im_we/addr/wdata  instruction-memory write port
//   cpu_rstn, cpu_ce  CPU reset (active-low) and clock enable
//   cpu_pc            current CPU program counter
//   reg_sel/reg_data  CPU register-read port (reg_data combinational)
//   state, halted     controller state and state==HALT flag
// ---------------------------------------------------------------------------
module sccomp_dbg_ctrl #(
   parameter int IM_AW    = 10,
   parameter int IM_DEPTH = 1024,
   parameter int STEP_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   sccomp_dbg_ctrl_if.slave     host,
   output logic                 im_we,
   output logic [IM_AW-1:0]     im_addr,
   output logic [31:0]          im_wdata,
   output logic                 cpu_rstn,
   output logic                 cpu_ce,
   input  logic [31:0]          cpu_pc,
   output logic [4:0]           reg_sel,
   input  logic [31:0]          reg_data,
   output logic [2:0]           state,
   output logic                 halted
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_RUN  = 3'd2,
      ST_STEP = 3'd3,
      ST_HALT = 3'd4,
      ST_DUMP = 3'd5
   } state_t;

   localparam logic [2:0] OP_LOAD    = 3'd1;
   localparam logic [2:0] OP_RUN     = 3'd2;
   localparam logic [2:0] OP_STEP    = 3'd3;
   localparam logic [2:0] OP_HALT    = 3'd4;
   localparam logic [2:0] OP_BRK_SET = 3'd5;
   localparam logic [2:0] OP_BRK_CLR = 3'd6;
   localparam logic [2:0] OP_DUMP    = 3'd7;

   localparam logic [IM_AW:0]    LD_ONE   = (IM_AW+1)'(1);
   localparam logic [IM_AW:0]    LD_DEPTH = (IM_AW+1)'(IM_DEPTH);
   localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

   state_t            state_reg, state_next;
   state_t            ret_state_reg;
   logic              cpu_rstn_reg;
   logic              im_we_reg;
   logic [IM_AW-1:0]  im_addr_reg;
   logic [31:0]       im_wdata_reg;
   logic              ld_ready_reg;
   logic [IM_AW:0]    ld_n_reg;
   logic [IM_AW:0]    ld_cnt_reg;
   logic [4:0]        reg_sel_reg;
   logic              dump_valid_reg;
   logic [31:0]       dump_data_reg;
   logic [4:0]        dump_idx_reg;
   logic              brk_en_reg;
   logic [31:0]       brk_pc_reg;
   logic              skip_reg;
   logic [STEP_W-1:0] step_cnt_reg;

   logic              cmd_ready_c;
   logic              cmd_fire;
   logic              idle_or_halt;
   logic              ld_nonzero;
   logic [IM_AW:0]    ld_n_clip;
   logic [STEP_W-1:0] step_arg;
   logic              acc_load, acc_run, acc_step, acc_dump;
   logic              acc_brk_set, acc_brk_clr;
   logic              ld_fire, ld_last;
   logic              dump_fire, dump_last;
   logic              brk_hit;
   logic              exec_state;
   logic              cpu_ce_c;

   // ------------------------------------------------------------------
   // Command decode
   // ------------------------------------------------------------------
   assign cmd_fire     = host.cmd_valid & cmd_ready_c;
   assign idle_or_halt = (state_reg == ST_IDLE) || (state_reg == ST_HALT);
   assign ld_nonzero   = |host.cmd_arg;
   assign ld_n_clip    = (host.cmd_arg > 32'(IM_DEPTH)) ? LD_DEPTH
                                                         : host.cmd_arg[IM_AW:0];
   // A zero step count still executes one instruction.
   assign step_arg     = (host.cmd_arg[STEP_W-1:0] == '0) ? STEP_ONE
                                                          : host.cmd_arg[STEP_W-1:0];

   assign acc_load    = cmd_fire && idle_or_halt && (host.cmd_op == OP_LOAD) && ld_nonzero;
   assign acc_run     = cmd_fire && idle_or_halt && (host.cmd_op == OP_RUN);
   assign acc_step    = cmd_fire && idle_or_halt && (host.cmd_op == OP_STEP);
   assign acc_dump    = cmd_fire && idle_or_halt && (host.cmd_op == OP_DUMP);
   assign acc_brk_set = cmd_fire && (host.cmd_op == OP_BRK_SET);
   assign acc_brk_clr = cmd_fire && (host.cmd_op == OP_BRK_CLR);

   assign ld_fire   = host.ld_valid & ld_ready_reg;
   assign ld_last   = ld_fire && ((ld_cnt_reg + LD_ONE) == ld_n_reg);
   assign dump_fire = dump_valid_reg & host.dump_ready;
   assign dump_last = dump_fire && (dump_idx_reg == 5'd31);

   // skip masks the breakpoint for the first instruction after a resume,
   // otherwise resuming at the breakpoint PC would halt again immediately.
   assign brk_hit    = brk_en_reg && (cpu_pc == brk_pc_reg) && !skip_reg;
   assign exec_state = (state_reg == ST_RUN) ||
                       ((state_reg == ST_STEP) && (step_cnt_reg != '0));

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE, ST_HALT: begin
            if (acc_load) state_next = ST_LOAD;
            if (acc_run)  state_next = ST_RUN;
            if (acc_step) state_next = ST_STEP;
            if (acc_dump) state_next = ST_DUMP;
         end
         ST_LOAD: begin
            if (ld_last) state_next = ST_IDLE;
         end
         ST_RUN: begin
            if ((cmd_fire && (host.cmd_op == OP_HALT)) || brk_hit) state_next = ST_HALT;
         end
         ST_STEP: begin
            // A count of zero means the requested instructions have all run.
            if (brk_hit || (step_cnt_reg == '0)) state_next = ST_HALT;
         end
         ST_DUMP: begin
            if (dump_last) state_next = ret_state_reg;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: state-decoded outputs
   // ------------------------------------------------------------------
   always_comb begin
      cmd_ready_c = 1'b0;
      cpu_ce_c    = 1'b0;
      halted      = 1'b0;
      case (state_reg)
         ST_IDLE: cmd_ready_c = 1'b1;
         ST_RUN:  cmd_ready_c = 1'b1;
         ST_HALT: begin
            cmd_ready_c = 1'b1;
            halted      = 1'b1;
         end
         default: cmd_ready_c = 1'b0;
      endcase
      cpu_ce_c = exec_state && !brk_hit;
   end

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         ret_state_reg  <= ST_IDLE;
         cpu_rstn_reg   <= 1'b0;
         im_we_reg      <= 1'b0;
         im_addr_reg    <= '0;
         im_wdata_reg   <= '0;
         ld_ready_reg   <= 1'b0;
         ld_n_reg       <= '0;
         ld_cnt_reg     <= '0;
         reg_sel_reg    <= '0;
         dump_valid_reg <= 1'b0;
         dump_data_reg  <= '0;
         dump_idx_reg   <= '0;
         brk_en_reg     <= 1'b0;
         brk_pc_reg     <= '0;
         skip_reg       <= 1'b0;
         step_cnt_reg   <= '0;
      end else begin
         im_we_reg <= 1'b0;

         if (acc_brk_set) begin
            brk_en_reg <= 1'b1;
            brk_pc_reg <= host.cmd_arg;
         end
         if (acc_brk_clr) begin
            brk_en_reg <= 1'b0;
         end

         if (cpu_ce_c) begin
            skip_reg <= 1'b0;
            if (state_reg == ST_STEP) step_cnt_reg <= step_cnt_reg - STEP_ONE;
         end

         if (acc_load) begin
            cpu_rstn_reg <= 1'b0;
            ld_ready_reg <= 1'b1;
            ld_n_reg     <= ld_n_clip;
            ld_cnt_reg   <= '0;
         end
         if (acc_run || acc_step) begin
            cpu_rstn_reg <= 1'b1;
            skip_reg     <= (state_reg == ST_HALT);
         end
         if (acc_step) begin
            step_cnt_reg <= step_arg;
         end
         if (acc_dump) begin
            reg_sel_reg   <= '0;
            ret_state_reg <= state_reg;
         end

         // Each accepted load word becomes a one-cycle IM write.
         if (ld_fire) begin
            im_we_reg    <= 1'b1;
            im_addr_reg  <= ld_cnt_reg[IM_AW-1:0];
            im_wdata_reg <= host.ld_data;
            ld_cnt_reg   <= ld_cnt_reg + LD_ONE;
            if (ld_last) ld_ready_reg <= 1'b0;
         end

         // Dump: capture reg_data one cycle after reg_sel settles, hold the
         // beat until accepted, then move to the next register (wraps to 0
         // after register 31).
         if (state_reg == ST_DUMP) begin
            if (!dump_valid_reg) begin
               dump_valid_reg <= 1'b1;
               dump_data_reg  <= reg_data;
               dump_idx_reg   <= reg_sel_reg;
            end else if (host.dump_ready) begin
               dump_valid_reg <= 1'b0;
               reg_sel_reg    <= reg_sel_reg + 5'd1;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Output mapping
   // ------------------------------------------------------------------
   assign host.cmd_ready  = cmd_ready_c;
   assign host.ld_ready   = ld_ready_reg;
   assign host.dump_valid = dump_valid_reg;
   assign host.dump_data  = dump_data_reg;
   assign host.dump_idx   = dump_idx_reg;
   assign im_we           = im_we_reg;
   assign im_addr         = im_addr_reg;
   assign im_wdata        = im_wdata_reg;
   assign cpu_rstn        = cpu_rstn_reg;
   assign cpu_ce          = cpu_ce_c;
   assign reg_sel         = reg_sel_reg;
   assign state           = state_reg;

endmodule

// File: tb/tb_sccomp_dbg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sccomp_dbg_ctrl
// Randomized bench for sccomp_dbg_ctrl. A tiny CPU model (PC that resets to 0
// and advances by 4 per enabled cycle, plus a register file) surrounds the
// controller. Stimulus pushes the expected IM writes and dump beats into
// queues; a monitor pops and compares them as the DUT presents them.
// ---------------------------------------------------------------------------
module tb_sccomp_dbg_ctrl;
   localparam int IM_AW    = 10;
   localparam int IM_DEPTH = 1024;

   localparam logic [2:0] OP_LOAD    = 3'd1;
   localparam logic [2:0] OP_RUN     = 3'd2;
   localparam logic [2:0] OP_STEP    = 3'd3;
   localparam logic [2:0] OP_HALT    = 3'd4;
   localparam logic [2:0] OP_BRK_SET = 3'd5;
   localparam logic [2:0] OP_BRK_CLR = 3'd6;
   localparam logic [2:0] OP_DUMP    = 3'd7;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sccomp_dbg_ctrl_if bus();

   logic             im_we;
   logic [IM_AW-1:0] im_addr;
   logic [31:0]      im_wdata;
   logic             cpu_rstn;
   logic             cpu_ce;
   logic [31:0]      cpu_pc = 32'd0;
   logic [4:0]       reg_sel;
   logic [31:0]      reg_data;
   logic [2:0]       state;
   logic             halted;

   logic [31:0] regs [32];
   assign reg_data = regs[reg_sel];

   // CPU model: PC held at 0 in reset, advances one word per enabled cycle.
   always @(posedge clk) begin
      if (!cpu_rstn)   cpu_pc <= 32'd0;
      else if (cpu_ce) cpu_pc <= cpu_pc + 32'd4;
   end

   sccomp_dbg_ctrl #(.IM_AW(IM_AW), .IM_DEPTH(IM_DEPTH), .STEP_W(16)) dut (
      .clk(clk), .rst(rst), .host(bus.slave),
      .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
      .cpu_rstn(cpu_rstn), .cpu_ce(cpu_ce), .cpu_pc(cpu_pc),
      .reg_sel(reg_sel), .reg_data(reg_data),
      .state(state), .halted(halted)
   );

   int checks = 0;
   int errors = 0;

   logic [41:0] exp_im_q   [$];   // {addr, data}
   logic [36:0] exp_dump_q [$];   // {idx, data}
   logic [31:0] ld_words   [$];
   logic [31:0] model_pc;
   int          rdy_mode = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ---------------- scoreboard monitor ----------------
   logic        prev_stall = 1'b0;
   logic [36:0] prev_beat  = '0;
   logic [41:0] e_im;
   logic [36:0] e_dump;

   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (im_we) begin
            $display("im write addr=%0d data=0x%08h", im_addr, im_wdata);
            if (exp_im_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL im_unexpected: got addr %0d data 0x%08h, expected no write", im_addr, im_wdata);
            end else begin
               e_im = exp_im_q.pop_front();
               check("im_addr", 64'(im_addr), 64'(e_im[41:32]));
               check("im_wdata", 64'(im_wdata), 64'(e_im[31:0]));
            end
         end
         if (state == 3'd1) check("rstn_in_load", 64'(cpu_rstn), 64'd0);
         if (state == 3'd5) check("ce_in_dump", 64'(cpu_ce), 64'd0);
         if (prev_stall)
            check("dump_hold", {26'd0, bus.dump_valid, bus.dump_idx, bus.dump_data}, {26'd0, 1'b1, prev_beat});
         if (bus.dump_valid && bus.dump_ready) begin
            $display("dump beat idx=%0d data=0x%08h", bus.dump_idx, bus.dump_data);
            if (exp_dump_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL dump_unexpected: got idx %0d, expected no beat", bus.dump_idx);
            end else begin
               e_dump = exp_dump_q.pop_front();
               check("dump_idx", 64'(bus.dump_idx), 64'(e_dump[36:32]));
               check("dump_data", 64'(bus.dump_data), 64'(e_dump[31:0]));
            end
         end
         prev_stall = bus.dump_valid && !bus.dump_ready;
         prev_beat  = {bus.dump_idx, bus.dump_data};
      end
   end

   // dump_ready driver: toggling or random
   initial begin
      bus.dump_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (rdy_mode == 0) bus.dump_ready = ~bus.dump_ready;
         else               bus.dump_ready = ($urandom_range(0, 1) != 0);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send_cmd(input logic [2:0] op, input logic [31:0] arg);
      int t = 0;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_arg   = arg;
      @(negedge clk);
      while (!bus.cmd_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("cmd_accept_timeout", 64'(t < 100), 64'd1);
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      $display("cmd op=%0d arg=0x%08h issued", op, arg);
   endtask

   task automatic load_seq(input logic [31:0] n_arg, input bit gap);
      int n = (n_arg > 32'(IM_DEPTH)) ? IM_DEPTH : int'(n_arg);
      int t;
      send_cmd(OP_LOAD, n_arg);
      if (n > 0) check("cmd_ready_in_load", 64'(bus.cmd_ready), 64'd0);
      for (int k = 0; k < n; k++) begin
         if (gap) begin
            bus.ld_valid = 1'b0;
            tick(1);
         end
         bus.ld_valid = 1'b1;
         bus.ld_data  = ld_words[k];
         exp_im_q.push_back({10'(k), ld_words[k]});
         t = 0;
         @(negedge clk);
         while (!bus.ld_ready && t < 50) begin
            @(negedge clk);
            t++;
         end
         if (t >= 50) begin
            checks++; errors++;
            $display("FAIL ld_ready_timeout: got ld_ready 0, expected 1 for word %0d", k);
            bus.ld_valid = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
         bus.ld_valid = 1'b0;
      end
      tick(2);
      check("load_end_state", 64'(state), 64'd0);
      check("load_end_ld_ready", 64'(bus.ld_ready), 64'd0);
      check("load_im_q_empty", 64'(exp_im_q.size()), 64'd0);
      model_pc = 32'd0;
   endtask

   task automatic run_until_halt(output int n_ce, output logic [31:0] halt_pc);
      int t = 0;
      n_ce = 0;
      @(negedge clk);
      while (!halted && t < 300) begin
         if (cpu_ce) n_ce++;
         t++;
         @(negedge clk);
      end
      check("halt_timeout", 64'(halted), 64'd1);
      halt_pc = cpu_pc;
      @(posedge clk);
      #1;
   endtask

   task automatic step_check(input logic [31:0] arg, input int exp_ce);
      int n_ce;
      logic [31:0] hpc;
      send_cmd(OP_STEP, arg);
      run_until_halt(n_ce, hpc);
      model_pc = model_pc + 32'(4 * exp_ce);
      check("step_ce_count", 64'(n_ce), 64'(exp_ce));
      check("step_halt_pc", 64'(hpc), 64'(model_pc));
      check("step_state", 64'(state), 64'd4);
   endtask

   task automatic do_dump(input logic [2:0] ret);
      int t = 0;
      for (int i = 0; i < 32; i++) exp_dump_q.push_back({5'(i), regs[i]});
      send_cmd(OP_DUMP, 32'd0);
      check("dump_cmd_ready", 64'(bus.cmd_ready), 64'd0);
      while (state == 3'd5 && t < 1000) begin
         tick(1);
         t++;
      end
      check("dump_timeout", 64'(t < 1000), 64'd1);
      tick(1);
      check("dump_return_state", 64'(state), 64'(ret));
      check("dump_q_empty", 64'(exp_dump_q.size()), 64'd0);
   endtask

   task automatic check_reset_outputs();
      check("rst_state", 64'(state), 64'd0);
      check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
      check("rst_cpu_rstn", 64'(cpu_rstn), 64'd0);
      check("rst_cpu_ce", 64'(cpu_ce), 64'd0);
      check("rst_ld_ready", 64'(bus.ld_ready), 64'd0);
      check("rst_im_we", 64'(im_we), 64'd0);
      check("rst_im_addr", 64'(im_addr), 64'd0);
      check("rst_im_wdata", 64'(im_wdata), 64'd0);
      check("rst_reg_sel", 64'(reg_sel), 64'd0);
      check("rst_dump_valid", 64'(bus.dump_valid), 64'd0);
      check("rst_dump_data", 64'(bus.dump_data), 64'd0);
      check("rst_dump_idx", 64'(bus.dump_idx), 64'd0);
      check("rst_halted", 64'(halted), 64'd0);
   endtask

   // watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- main sequence ----------------
   initial begin
      int n_ce;
      int nrand;
      logic [31:0] hpc;
      logic [31:0] bp;

      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 3'd0;
      bus.cmd_arg   = 32'd0;
      bus.ld_valid  = 1'b0;
      bus.ld_data   = 32'd0;
      model_pc      = 32'd0;
      for (int i = 0; i < 32; i++) regs[i] = 32'(i * 32'h11);

      tick(3);
      @(negedge clk);
      check_reset_outputs();
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick(1);

      // Load the four-instruction program with gaps on ld_valid.
      ld_words = '{32'h20080005, 32'h20090003, 32'h01095020, 32'hAC0A0000};
      load_seq(32'd4, 1'b1);

      // LOAD of zero words does nothing.
      send_cmd(OP_LOAD, 32'd0);
      check("load0_state", 64'(state), 64'd0);
      check("load0_ld_ready", 64'(bus.ld_ready), 64'd0);

      // Random short load without gaps.
      nrand = $urandom_range(1, 8);
      ld_words.delete();
      for (int i = 0; i < nrand; i++) ld_words.push_back($urandom);
      load_seq(32'(nrand), 1'b0);

      // Oversized count is clipped to the full memory depth.
      ld_words.delete();
      for (int i = 0; i < IM_DEPTH; i++) ld_words.push_back($urandom);
      load_seq(32'hFFFF_FFFF, 1'b0);

      // Single-stepping from IDLE, then from HALT.
      step_check(32'd3, 3);
      check("step_rstn", 64'(cpu_rstn), 64'd1);
      step_check(32'd0, 1);
      step_check(32'h0001_0003, 3);
      repeat (3) begin
         nrand = $urandom_range(1, 20);
         step_check(32'(nrand), nrand);
      end

      // Breakpoint two instructions ahead stops a long step early; the next
      // step resumes past it.
      bp = model_pc + 32'd8;
      send_cmd(OP_BRK_SET, bp);
      step_check(32'd10, 2);
      step_check(32'd1, 1);
      send_cmd(OP_BRK_CLR, 32'd0);

      // Register dump from HALT with dump_ready toggling.
      rdy_mode = 0;
      do_dump(3'd4);

      // Reload program, run to breakpoint at 0x0C, resume past it.
      ld_words = '{32'h20080005, 32'h20090003, 32'h01095020, 32'hAC0A0000};
      load_seq(32'd4, 1'b1);
      send_cmd(OP_BRK_SET, 32'h0000_000C);
      send_cmd(OP_RUN, 32'd0);
      run_until_halt(n_ce, hpc);
      check("brk_ce_count", 64'(n_ce), 64'd3);
      check("brk_halt_pc", 64'(hpc), 64'h0C);
      send_cmd(OP_RUN, 32'd0);
      @(negedge clk);
      check("resume_ce", 64'(cpu_ce), 64'd1);
      check("resume_pc", 64'(cpu_pc), 64'h0C);
      tick(4);
      check("resume_running", 64'(state), 64'd2);
      send_cmd(OP_STEP, 32'd5);
      check("step_in_run_dropped", 64'(state), 64'd2);
      send_cmd(OP_HALT, 32'd0);
      check("halt_cmd_state", 64'(state), 64'd4);
      @(negedge clk);
      check("halt_cmd_ce", 64'(cpu_ce), 64'd0);
      send_cmd(OP_BRK_CLR, 32'd0);

      // Dump from IDLE with random register contents and random ready.
      ld_words = '{32'h1234_5678};
      load_seq(32'd1, 1'b0);
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      rdy_mode = 1;
      do_dump(3'd0);

      // Reset in the middle of a load; breakpoint must be cleared too.
      send_cmd(OP_BRK_SET, 32'd0);
      ld_words = '{32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003, 32'hA5A5_0004};
      send_cmd(OP_LOAD, 32'd4);
      for (int k = 0; k < 2; k++) begin
         bus.ld_valid = 1'b1;
         bus.ld_data  = ld_words[k];
         exp_im_q.push_back({10'(k), ld_words[k]});
         tick(1);
      end
      bus.ld_valid = 1'b0;
      tick(1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs();
      check("rst_im_q_empty", 64'(exp_im_q.size()), 64'd0);
      @(posedge clk);
      #1;
      ld_words = '{32'hDEAD_BEEF};
      load_seq(32'd1, 1'b0);
      send_cmd(OP_RUN, 32'd0);
      @(negedge clk);
      check("rst_brk_cleared_ce", 64'(cpu_ce), 64'd1);
      send_cmd(OP_HALT, 32'd0);
      check("final_halt", 64'(state), 64'd4);

      tick(2);
      check("final_im_q", 64'(exp_im_q.size()), 64'd0);
      check("final_dump_q", 64'(exp_dump_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
